mac_frame_gen_lanes: RTL
========================

# mac_frame_gen_lanes

Parametrised successor to the MII MAC frame generator. It produces complete Ethernet frames on a DATA_BYTES-lane MII-style data/control bus: start, preamble, SFD, header, pattern payload, optional padding, CRC-32 FCS, terminate and inter-packet gap. It supports bursts of N frames or continuous generation, and optional FCS corruption. It sits between the test-traffic control logic and the PCS encoder.

## Interface
- DATA_BYTES, 8: lanes per word; legal values are 4 or 8.
- PAYLOAD_MAX_SIZE, 1500: payload length ceiling in bytes.
- IPG_BYTES, 12: minimum gap in bytes.

- clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  pulse that starts a burst; ignored while o_busy=1
- i_stop  in  1  ends the burst after the current frame and its IPG complete
- i_frame_count  in  16  frames per burst; 0 means continuous until i_stop
- i_dest_address  in  48  DA, sent MSB byte first
- i_src_address  in  48  SA, sent MSB byte first
- i_eth_type  in  16  EtherType/length, sent MSB byte first
- i_payload_length  in  16  payload bytes; values above PAYLOAD_MAX_SIZE saturate to PAYLOAD_MAX_SIZE
- i_pattern_byte  in  8  fixed payload byte
- i_mode  in  3  bit0 no_padding; bit1 corrupt_fcs; bit2 incrementing pattern
- o_mii_data  out  8*DATA_BYTES  lane k = bits [8k+7:8k]; lane 0 is first on the wire
- o_mii_ctrl  out  DATA_BYTES  1 = the lane carries a control character
- o_tx_valid  out  1  high on every word from the Start word through the Terminate word
- o_busy  out  1  high while a burst is active
- o_done  out  1  one-cycle pulse when the burst ends
- o_frame_cnt  out  16  frames completed in the current burst

## Operation
- States:
  - IDLE: i_start moves the block to FRAME.
  - FRAME: on the word containing Terminate, move to IPG.
  - IPG: after the gap, move to FRAME if frames remain and i_stop has not been seen; otherwise move to IDLE and pulse o_done.
- Config latch: all i_* config inputs are latched at each frame start, so changes mid-frame take effect on the next frame.
- Byte stream per frame, with b = byte index from 0:
  - b=0: Start 0xFB, ctrl=1.
  - b=1..6: 0x55.
  - b=7: SFD 0xD5.
  - Then DA (6), SA (6), type (2).
  - Then payload P bytes.
  - Then pad bytes 0x00 up to 46 payload+pad bytes, unless no_padding is set.
  - Then FCS (4).
  - Then Terminate 0xFD, ctrl=1.
  - Remaining lanes of that word: Idle 0x07, ctrl=1.
- Frame length: L = 14 + max(P,46) + 4, or 14 + P + 4 when no_padding is set. Terminate sits at b = 8 + L.
- Word w carries bytes b = w*DATA_BYTES + k. Start is always in lane 0.
- Payload byte j:
  - i_pattern_byte when bit2=0.
  - j[7:0] when bit2=1.
- FCS: IEEE 802.3 CRC-32, reflected, init 0xFFFFFFFF, final XOR 0xFFFFFFFF.
  - Computed over DA through the last pad byte, processing up to DATA_BYTES bytes per cycle.
  - Sent least-significant byte first.
  - When corrupt_fcs is set, send the bitwise inverse.
- IPG: after the Terminate word, send ceil(IPG_BYTES/DATA_BYTES) all-Idle words (o_mii_ctrl all ones).
- IDLE output: o_mii_data is 0x07 in every lane, o_mii_ctrl all ones, o_tx_valid=0.
- o_frame_cnt:
  - Increments on each Terminate word.
  - Clears on burst start.
  - Holds its value after o_done.
- i_stop:
  - Sampled in any state while busy.
  - Sets a sticky flag that is cleared on burst start.
  - The current frame and its IPG always complete.

## Timing
- All outputs are registered.
- Reset values: o_mii_data is all lanes 0x07, o_mii_ctrl all ones, o_tx_valid=0, o_busy=0, o_done=0, o_frame_cnt=0.
- Start latency: i_start high at edge t puts the Start word on the outputs after edge t+1. o_busy rises at the same time.
- Frame spacing: consecutive frames are back-to-back after the IPG words, with no extra bubble.
- End of burst: o_done pulses in the cycle after the last IPG word. o_busy falls in that same cycle.
- Simultaneous i_start and i_stop in IDLE: the burst starts, exactly one frame is sent, then o_done.
- Reset mid-frame: the next cycle shows IDLE output. No Terminate is sent, and all counters and the CRC are cleared.
- i_frame_count=1: single frame, then IDLE.

## Test plan
- DATA_BYTES=8, P=49, pattern 0xAA, count=1:
  - 10 frame words; Terminate in word 9 lane 3, lanes 4-7 Idle.
  - 2 IPG words, then o_done.
  - FCS matches the bench CRC model.
  - o_frame_cnt=1.
- DATA_BYTES=8, P=8, padding on: 38 pad bytes of 0x00; Terminate in word 9 lane 0.
- Same as above with no_padding set: L=26; Terminate in word 4 lane 2.
- DATA_BYTES=4, P=49, incrementing pattern, count=3:
  - Each frame is 19 words, Terminate in word 18 lane 3.
  - 3 IPG words between frames.
  - Payload is 0x00..0x30.
  - o_frame_cnt=3.
- Continuous mode (count=0), corrupt_fcs on, i_stop asserted mid-frame 2:
  - Frame 2 completes, with FCS equal to the inverse of the model value.
  - IPG follows, then o_done; o_frame_cnt=2.
- i_rst pulsed mid-payload: the next word is all Idle, o_busy=0, o_frame_cnt=0. A fresh i_start then yields a correct frame.

Source files
------------

// File: rtl/mac_frame_gen_lanes.sv
// -----------------------------------------------------------------------------
// mac_frame_gen_lanes
//
// Generates complete Ethernet frames on a DATA_BYTES-lane MII-style bus:
// Start, preamble, SFD, DA/SA/type header, pattern payload, optional zero
// padding, CRC-32 FCS, Terminate and an all-Idle inter-packet gap. It can send
// a burst of N frames or run continuously until stopped, and can optionally
// invert the FCS to produce deliberately bad frames.
//
// Parameters
//   DATA_BYTES        lanes per word (4 or 8)
//   PAYLOAD_MAX_SIZE  payload length ceiling in bytes
//   IPG_BYTES         minimum inter-packet gap in bytes
//
// Ports
//   clk               clock
//   i_rst             synchronous active-high reset
//   i_start           starts a burst (ignored while o_busy=1)
//   i_stop            ends the burst after the current frame and its gap
//   i_frame_count     frames per burst, 0 = continuous
//   i_dest_address    destination MAC, MSB byte first on the wire
//   i_src_address     source MAC, MSB byte first on the wire
//   i_eth_type        EtherType/length, MSB byte first on the wire
//   i_payload_length  payload bytes, saturated to PAYLOAD_MAX_SIZE
//   i_pattern_byte    fixed payload byte
//   i_mode            [0] no padding, [1] corrupt FCS, [2] incrementing payload
//   o_mii_data        lane k = bits [8k+7:8k], lane 0 first on the wire
//   o_mii_ctrl        per-lane control-character flag
//   o_tx_valid        high from the Start word through the Terminate word
//   o_busy            burst active
//   o_done            one-cycle pulse at the end of a burst
//   o_frame_cnt       frames completed in the current burst
// -----------------------------------------------------------------------------
module mac_frame_gen_lanes #(
    parameter int unsigned DATA_BYTES       = 8,
    parameter int unsigned PAYLOAD_MAX_SIZE = 1500,
    parameter int unsigned IPG_BYTES        = 12
) (
    input  logic                      clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic                      i_stop,
    input  logic [15:0]               i_frame_count,
    input  logic [47:0]               i_dest_address,
    input  logic [47:0]               i_src_address,
    input  logic [15:0]               i_eth_type,
    input  logic [15:0]               i_payload_length,
    input  logic [7:0]                i_pattern_byte,
    input  logic [2:0]                i_mode,
    output logic [8*DATA_BYTES-1:0]   o_mii_data,
    output logic [DATA_BYTES-1:0]     o_mii_ctrl,
    output logic                      o_tx_valid,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [15:0]               o_frame_cnt
);

    localparam int unsigned IPG_WORDS = (IPG_BYTES + DATA_BYTES - 1) / DATA_BYTES;
    localparam logic [15:0] IPG_LAST  = 16'(IPG_WORDS - 1);
    localparam logic [15:0] PMAX      = 16'(PAYLOAD_MAX_SIZE);
    localparam logic [15:0] MIN_BODY  = 16'd46;

    localparam logic [8*DATA_BYTES-1:0] IDLE_DATA = {DATA_BYTES{8'h07}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_FRAME,
        S_IPG
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Per-frame configuration snapshot
    logic [47:0] r_da;
    logic [47:0] r_sa;
    logic [15:0] r_type;
    logic [15:0] r_plen;
    logic [7:0]  r_pattern;
    logic [2:0]  r_mode;
    // Per-burst state
    logic [15:0] r_count;
    logic        r_stop;
    logic [15:0] r_frame_cnt;

    logic [15:0] r_word;
    logic [15:0] r_ipg;
    logic [31:0] r_crc;

    logic [8*DATA_BYTES-1:0] r_mii_data;
    logic [DATA_BYTES-1:0]   r_mii_ctrl;
    logic                    r_tx_valid;
    logic                    r_busy;
    logic                    r_done;

    logic                    w_frame_start;
    logic                    w_burst_start;
    logic                    w_more;
    logic [15:0]             w_body;
    logic [15:0]             w_fcs_b;
    logic [15:0]             w_term_b;
    logic [15:0]             w_base;
    logic                    w_term_word;
    logic [31:0]             w_crc;
    logic [8*DATA_BYTES-1:0] w_lane_data;
    logic [DATA_BYTES-1:0]   w_lane_ctrl;

    // Reflected CRC-32 (poly 0xEDB88320), one byte, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] x;
        x = c ^ {24'h0, d};
        for (int unsigned i = 0; i < 8; i++) begin
            x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
        end
        return x;
    endfunction

    // Frame geometry derived from the snapshot
    always_comb begin
        w_body      = (r_mode[0] || r_plen >= MIN_BODY) ? r_plen : MIN_BODY;
        w_fcs_b     = 16'd22 + w_body;
        w_term_b    = w_fcs_b + 16'd4;
        w_base      = 16'(r_word * DATA_BYTES);
        w_term_word = (w_term_b >= w_base) && ((w_term_b - w_base) < 16'(DATA_BYTES));
        w_more      = !r_stop && !i_stop && ((r_count == '0) || (r_frame_cnt < r_count));
    end

    // Lane generation. Lanes are walked in wire order so the running CRC has
    // absorbed every data byte of this word before any FCS lane reads it; an
    // FCS split across two words sees r_crc unchanged in the second word.
    always_comb begin
        logic [15:0] b;
        logic [7:0]  d;
        logic        c;
        w_crc       = r_crc;
        w_lane_data = IDLE_DATA;
        w_lane_ctrl = '1;
        for (int unsigned k = 0; k < DATA_BYTES; k++) begin
            b = w_base + 16'(k);
            d = 8'h07;
            c = 1'b1;
            if (b == 16'd0) begin
                d = 8'hFB;
            end else if (b < 16'd7) begin
                d = 8'h55;
                c = 1'b0;
            end else if (b == 16'd7) begin
                d = 8'hD5;
                c = 1'b0;
            end else if (b < w_fcs_b) begin
                c = 1'b0;
                if (b < 16'd14) begin
                    d = 8'(r_da >> (8 * (16'd13 - b)));
                end else if (b < 16'd20) begin
                    d = 8'(r_sa >> (8 * (16'd19 - b)));
                end else if (b == 16'd20) begin
                    d = r_type[15:8];
                end else if (b == 16'd21) begin
                    d = r_type[7:0];
                end else if (b < (16'd22 + r_plen)) begin
                    d = r_mode[2] ? 8'(b - 16'd22) : r_pattern;
                end else begin
                    d = 8'h00;
                end
                w_crc = crc_byte(w_crc, d);
            end else if (b < w_term_b) begin
                c = 1'b0;
                // Normal FCS is ~crc; the corrupted one is its inverse.
                d = 8'((r_mode[1] ? w_crc : ~w_crc) >> {2'(b - w_fcs_b), 3'b000});
            end else if (b == w_term_b) begin
                d = 8'hFD;
            end
            w_lane_data[8*k +: 8] = d;
            w_lane_ctrl[k]        = c;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        w_state_nxt   = r_state;
        w_frame_start = 1'b0;
        w_burst_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start && !r_busy) begin
                    w_state_nxt   = S_FRAME;
                    w_frame_start = 1'b1;
                    w_burst_start = 1'b1;
                end
            end
            S_FRAME: begin
                if (w_term_word) begin
                    w_state_nxt = S_IPG;
                end
            end
            S_IPG: begin
                if (r_ipg == IPG_LAST) begin
                    if (w_more) begin
                        w_state_nxt   = S_FRAME;
                        w_frame_start = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_da        <= '0;
            r_sa        <= '0;
            r_type      <= '0;
            r_plen      <= '0;
            r_pattern   <= '0;
            r_mode      <= '0;
            r_count     <= '0;
            r_stop      <= 1'b0;
            r_frame_cnt <= '0;
            r_word      <= '0;
            r_ipg       <= '0;
            r_crc       <= '1;
            r_mii_data  <= IDLE_DATA;
            r_mii_ctrl  <= '1;
            r_tx_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_frame_start) begin
                r_da      <= i_dest_address;
                r_sa      <= i_src_address;
                r_type    <= i_eth_type;
                r_plen    <= (i_payload_length > PMAX) ? PMAX : i_payload_length;
                r_pattern <= i_pattern_byte;
                r_mode    <= i_mode;
                r_word    <= '0;
                r_crc     <= '1;
            end else if (r_state == S_FRAME) begin
                r_word <= r_word + 16'd1;
                r_crc  <= w_crc;
            end

            r_ipg <= (r_state == S_IPG) ? (r_ipg + 16'd1) : '0;

            // A stop coinciding with the start is kept, giving a one-frame burst.
            if (w_burst_start) begin
                r_count     <= i_frame_count;
                r_stop      <= i_stop;
                r_frame_cnt <= '0;
            end else begin
                if (i_stop && r_state != S_IDLE) begin
                    r_stop <= 1'b1;
                end
                if (r_state == S_FRAME && w_term_word) begin
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end
            end

            if (r_state == S_FRAME) begin
                r_mii_data <= w_lane_data;
                r_mii_ctrl <= w_lane_ctrl;
            end else begin
                r_mii_data <= IDLE_DATA;
                r_mii_ctrl <= '1;
            end
            r_tx_valid <= (r_state == S_FRAME);
            r_busy     <= (r_state != S_IDLE);
            // Busy still showing the last gap word while the FSM is back in IDLE.
            r_done     <= (r_state == S_IDLE) && r_busy;
        end
    end

    assign o_mii_data  = r_mii_data;
    assign o_mii_ctrl  = r_mii_ctrl;
    assign o_tx_valid  = r_tx_valid;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_frame_cnt = r_frame_cnt;

endmodule
